player_key_encoder: RTL and testbench
=====================================

# player_key_encoder

Converts the PS/2 set-2 scancode byte stream from the keyboard receiver into the 4-bit movement keycode, `keyPress` and `Jumping` signals consumed by the player movement block. It tracks make/break state of W, A, S, D and Space, including E0/F0 prefix handling. It encodes diagonal combinations and delivers one frame-aligned jump request per new Space press. It sits between the PS/2 byte receiver and player movement, in the `Clk` domain.

## Interface
- `PREFIX_TIMEOUT`, 50000: cycles allowed between a prefix byte (E0/F0) and its code byte before the decoder abandons the sequence.
- `PLAY_STATE`, 2'b01: `gameState` value in which outputs are enabled.

Ports:
- `Clk`  in  1  system clock (50 MHz).
- `Reset`  in  1  reset, asynchronous, active-high.
- `scan_valid`  in  1  one-cycle strobe: `scan_code` holds a new byte.
- `scan_code`  in  8  received byte.
- `frame_tick`  in  1  one-cycle pulse per frame, synchronous to `Clk`, derived from VS.
- `gameState`  in  2  current game state.
- `keycode`  out  4  movement code: 0 none, 1 W, 2 A, 3 S, 4 D, 5 WA, 6 WD, 7 SA, 8 SD.
- `keyPress`  out  1  any of W/A/S/D/Space held.
- `Jumping`  out  1  latched jump request.

## Operation
- Held-key register, 5 bits: W=1D, A=1C, S=1B, D=23, Space=29. A make sets the bit; a break (F0 xx) clears it. Unmapped codes are ignored.
- Prefix FSM:
  - States: IDLE, BRK, EXT, EXT_BRK.
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other byte is a normal make and stays in IDLE.
  - BRK: F0 stays in BRK; E0 goes to EXT; any other byte is a normal break, then IDLE.
  - EXT: F0 goes to EXT_BRK; E0 stays in EXT; any other byte is an extended make, then IDLE.
  - EXT_BRK: E0 goes to EXT; F0 stays in EXT_BRK; any other byte is an extended break, then IDLE.
- Error bytes: 00 or FF in any state clears all held bits and forces IDLE.
- Timeout: a 16-bit counter runs in every non-IDLE state and is cleared on each `scan_valid`. When it reaches `PREFIX_TIMEOUT`, the FSM returns to IDLE. Held bits are untouched.
- Encoding:
  - Vertical V = W xor S. Both held cancels.
  - Horizontal H = A xor D. Both held cancels.
  - Combos: W+A gives 5, W+D 6, S+A 7, S+D 8. W only 1, A only 2, S only 3, D only 4. Nothing active gives 0.
- Jump latch:
  - Sets on a Space make only when the Space held bit was 0 (typematic repeats are ignored).
  - Clears on the second `frame_tick` after being set, so a VS-clocked consumer sees at least one full frame.
  - A new press while the latch is set restarts the tick count.
- Game state: when `gameState != PLAY_STATE`, `keycode`, `keyPress` and `Jumping` are forced to 0, the jump latch is cleared and cannot set, and key tracking continues.

## Timing
- Reset values: FSM IDLE, held bits 0, timeout counter 0, jump latch 0. `keycode`=0, `keyPress`=0, `Jumping`=0.
- Key latency: `scan_valid` with the final code byte at cycle N updates held bits at edge N+1. `keycode` and `keyPress` are combinational from held bits and valid in cycle N+1.
- Jump latency: `Jumping` is registered and asserts in cycle N+1 after a Space make.
- Simultaneous Space make and second `frame_tick` in one cycle: the set wins and the tick count restarts.
- Reset asserted mid-sequence (e.g. after F0) returns everything to reset values immediately. The pending break is lost.
- Prefix bytes produce no output change.

## Configuration
- `PLAYER_ARROW_KEYS_EN`:
  - Defined: extended codes E0 75, E0 6B, E0 72, E0 74 alias the W, A, S, D held bits respectively. Make and break are symmetric with the plain codes.
  - Not defined: all extended make and break codes are ignored. The FSM still consumes the E0 prefix.

## Test plan
- Reset, then bytes 1D, then 1C → `keycode`=5, `keyPress`=1. Then F0 1D → `keycode`=2.
- Make 1C and 23 (A+D) → `keycode`=0, `keyPress`=1. Then F0 23 → `keycode`=2.
- Space make 29 twice (repeat) with `frame_tick` pulses → `Jumping` high from N+1, low after the second tick, not re-raised by the repeat. F0 29, then 29 → `Jumping` high again.
- Byte F0, then no byte for 50000 cycles, then 1D → W treated as a make, `keycode`=1.
- `gameState`=2'b00 with W held → all outputs 0. Switch to 2'b01 → `keycode`=1 the same cycle.
- E0 75 → `keycode`=1 with `PLAYER_ARROW_KEYS_EN` defined, 0 without. An FF byte while D is held → `keycode`=0, FSM IDLE.

Source files
------------

// File: rtl/player_key_encoder.sv
// PS/2 set-2 WASD/Space tracker feeding player movement: keycode, keyPress, Jumping.
// Define PLAYER_ARROW_KEYS_EN to alias E0-prefixed arrow keys onto W/A/S/D.
module player_key_encoder #(
  parameter int         PREFIX_TIMEOUT = 50000,
  parameter logic [1:0] PLAY_STATE     = 2'b01
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic       frame_tick,
  input  logic [1:0] gameState,
  output logic [3:0] keycode,
  output logic       keyPress,
  output logic       Jumping
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t      state, state_nxt;
  logic [4:0]  held, held_nxt;
  logic [15:0] tmo_cnt;
  logic        jump_q, tick_seen;
  logic        space_make;
  logic        play;
  logic        up, dn, lf, rt;

  assign play = (gameState == PLAY_STATE);

  // bit order: {Space, D, S, A, W}
  function automatic logic [4:0] plain_mask(input logic [7:0] b);
    logic [4:0] m;
    m = 5'b0;
    case (b)
      8'h1D:   m = 5'b00001;
      8'h1C:   m = 5'b00010;
      8'h1B:   m = 5'b00100;
      8'h23:   m = 5'b01000;
      8'h29:   m = 5'b10000;
      default: m = 5'b0;
    endcase
    return m;
  endfunction

  function automatic logic [4:0] ext_mask(input logic [7:0] b);
    logic [4:0] m;
    m = 5'b0;
`ifdef PLAYER_ARROW_KEYS_EN
    case (b)
      8'h75:   m = 5'b00001;
      8'h6B:   m = 5'b00010;
      8'h72:   m = 5'b00100;
      8'h74:   m = 5'b01000;
      default: m = 5'b0;
    endcase
`else
    m = {5{b[0] & 1'b0}};
`endif
    return m;
  endfunction

  always_comb begin
    state_nxt  = state;
    held_nxt   = held;
    space_make = 1'b0;
    if (scan_valid) begin
      if (scan_code == 8'h00 || scan_code == 8'hFF) begin
        held_nxt  = 5'b0;
        state_nxt = IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (scan_code == 8'hE0)      state_nxt = EXT;
            else if (scan_code == 8'hF0) state_nxt = BRK;
            else begin
              held_nxt   = held | plain_mask(scan_code);
              space_make = (scan_code == 8'h29) && !held[4];
            end
          end
          BRK: begin
            if (scan_code == 8'hE0)      state_nxt = EXT;
            else if (scan_code != 8'hF0) begin
              held_nxt  = held & ~plain_mask(scan_code);
              state_nxt = IDLE;
            end
          end
          EXT: begin
            if (scan_code == 8'hF0)      state_nxt = EXT_BRK;
            else if (scan_code != 8'hE0) begin
              held_nxt  = held | ext_mask(scan_code);
              state_nxt = IDLE;
            end
          end
          EXT_BRK: begin
            if (scan_code == 8'hE0)      state_nxt = EXT;
            else if (scan_code != 8'hF0) begin
              held_nxt  = held & ~ext_mask(scan_code);
              state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if (state != IDLE && tmo_cnt == 16'(PREFIX_TIMEOUT)) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      held    <= 5'b0;
      tmo_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      held  <= held_nxt;
      if (scan_valid || state == IDLE)
        tmo_cnt <= 16'd0;
      else if (tmo_cnt != 16'(PREFIX_TIMEOUT))
        tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // A fresh press restarts the two-tick hold window.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      jump_q    <= 1'b0;
      tick_seen <= 1'b0;
    end else if (!play) begin
      jump_q    <= 1'b0;
      tick_seen <= 1'b0;
    end else if (space_make) begin
      jump_q    <= 1'b1;
      tick_seen <= 1'b0;
    end else if (jump_q && frame_tick) begin
      if (tick_seen) begin
        jump_q    <= 1'b0;
        tick_seen <= 1'b0;
      end else begin
        tick_seen <= 1'b1;
      end
    end
  end

  assign up = held[0] & ~held[2];
  assign dn = held[2] & ~held[0];
  assign lf = held[1] & ~held[3];
  assign rt = held[3] & ~held[1];

  always_comb begin
    keycode = 4'd0;
    if (play) begin
      case ({up, dn, lf, rt})
        4'b1000: keycode = 4'd1;
        4'b0010: keycode = 4'd2;
        4'b0100: keycode = 4'd3;
        4'b0001: keycode = 4'd4;
        4'b1010: keycode = 4'd5;
        4'b1001: keycode = 4'd6;
        4'b0110: keycode = 4'd7;
        4'b0101: keycode = 4'd8;
        default: keycode = 4'd0;
      endcase
    end
  end

  assign keyPress = play & (|held);
  assign Jumping  = play & jump_q;

endmodule

// File: tb/tb_player_key_encoder.sv
// Directed bench for player_key_encoder: key combos, prefixes, jump latch,
// timeout, game-state gating, error bytes and reset.
module tb_player_key_encoder;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       frame_tick;
  logic [1:0] gameState;
  logic [3:0] keycode;
  logic       keyPress;
  logic       Jumping;

  int n_vec = 0;
  int n_bad = 0;

  player_key_encoder dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .frame_tick (frame_tick),
    .gameState  (gameState),
    .keycode    (keycode),
    .keyPress   (keyPress),
    .Jumping    (Jumping)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] kc,
                         input logic kp, input logic jp);
    chk({tag, ".keycode"}, keycode, kc);
    chk({tag, ".keyPress"}, {3'b0, keyPress}, {3'b0, kp});
    chk({tag, ".Jumping"}, {3'b0, Jumping}, {3'b0, jp});
  endtask

  task automatic send(input logic [7:0] b, input logic tk = 1'b0);
    @(negedge Clk);
    scan_valid = 1'b1;
    scan_code  = b;
    frame_tick = tk;
    @(negedge Clk);
    scan_valid = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic tick();
    @(negedge Clk);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    Reset      = 1'b1;
    scan_valid = 1'b0;
    scan_code  = 8'h00;
    frame_tick = 1'b0;
    gameState  = 2'b01;
    repeat (3) @(negedge Clk);
    chk_all("reset", 4'd0, 1'b0, 1'b0);
    Reset = 1'b0;

    send(8'h1D); chk_all("W", 4'd1, 1'b1, 1'b0);
    send(8'h1C); chk_all("WA", 4'd5, 1'b1, 1'b0);
    send(8'hF0); chk("prefix_hold", keycode, 4'd5);
    send(8'h1D); chk_all("brk_W", 4'd2, 1'b1, 1'b0);

    send(8'h23); chk_all("AD_cancel", 4'd0, 1'b1, 1'b0);
    send(8'hF0); send(8'h23); chk("brk_D", keycode, 4'd2);
    send(8'hF0); send(8'h1C); chk_all("none", 4'd0, 1'b0, 1'b0);
    send(8'h1B); send(8'h23); chk("SD", keycode, 4'd8);
    send(8'h1C); chk("SAD", keycode, 4'd3);
    send(8'h1D); chk("WSAD", keycode, 4'd0);
    send(8'hF0); send(8'h1B); chk("WAD", keycode, 4'd1);
    send(8'hF0); send(8'h23); chk("WA2", keycode, 4'd5);
    send(8'hF0); send(8'h1D); send(8'hF0); send(8'h1C);
    chk_all("clear", 4'd0, 1'b0, 1'b0);

    send(8'h29); chk_all("jump_set", 4'd0, 1'b1, 1'b1);
    tick();      chk("jump_tick1", {3'b0, Jumping}, 4'd1);
    send(8'h29); chk("jump_repeat", {3'b0, Jumping}, 4'd1);
    tick();      chk("jump_tick2", {3'b0, Jumping}, 4'd0);
    send(8'h29); chk("jump_no_rerise", {3'b0, Jumping}, 4'd0);
    send(8'hF0); send(8'h29); chk("space_rel", {3'b0, keyPress}, 4'd0);
    send(8'h29); chk("jump_again", {3'b0, Jumping}, 4'd1);
    tick();
    send(8'hF0); send(8'h29);
    send(8'h29); chk("jump_restart", {3'b0, Jumping}, 4'd1);
    tick();      chk("restart_t1", {3'b0, Jumping}, 4'd1);
    tick();      chk("restart_t2", {3'b0, Jumping}, 4'd0);
    send(8'hF0); send(8'h29);
    send(8'h29); tick();
    send(8'hF0); send(8'h29);
    send(8'h29, 1'b1); chk("set_wins", {3'b0, Jumping}, 4'd1);
    tick();      chk("set_wins_t1", {3'b0, Jumping}, 4'd1);
    tick();      chk("set_wins_t2", {3'b0, Jumping}, 4'd0);
    send(8'hF0); send(8'h29);

    send(8'hF0);
    repeat (50010) @(negedge Clk);
    send(8'h1D); chk("timeout_make", keycode, 4'd1);

    gameState = 2'b00; #1;
    chk_all("gated", 4'd0, 1'b0, 1'b0);
    send(8'h29); chk("gated_jump", {3'b0, Jumping}, 4'd0);
    gameState = 2'b01; #1;
    chk_all("ungated", 4'd1, 1'b1, 1'b0);
    send(8'hF0); send(8'h29);
    send(8'h29); chk("jump_pre_gate", {3'b0, Jumping}, 4'd1);
    gameState = 2'b00;
    @(negedge Clk);
    gameState = 2'b01; #1;
    chk("jump_gate_clr", {3'b0, Jumping}, 4'd0);
    send(8'hF0); send(8'h29);

    send(8'hF0); send(8'h1D); chk("W_off", keycode, 4'd0);
    send(8'hE0); send(8'h1D); chk("ext_W_ignored", keycode, 4'd0);
    send(8'hE0); send(8'h75);
`ifdef PLAYER_ARROW_KEYS_EN
    chk("arrow_up", keycode, 4'd1);
`else
    chk("arrow_up", keycode, 4'd0);
`endif
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("arrow_up_brk", keycode, 4'd0);
    send(8'h23); chk("D", keycode, 4'd4);
    send(8'hF0); send(8'hFF); chk_all("err_FF", 4'd0, 1'b0, 1'b0);
    send(8'h1D); chk("err_idle", keycode, 4'd1);

    send(8'hF0);
    #2 Reset = 1'b1; #1;
    chk_all("mid_reset", 4'd0, 1'b0, 1'b0);
    @(negedge Clk); Reset = 1'b0;
    send(8'h1D); chk("post_reset_make", keycode, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
